// File: rtl/mem_pkg.sv
// Shared opcode constants, FSM state type and address/lane helpers for the memory-access stage.
package mem_pkg;

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpSb  = 6'b101000;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSw  = 6'b101011;

  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

  typedef enum logic [1:0] {StIdle, StAccess, StAbort} state_e;

  typedef struct packed {
    logic [31:0] order;
    logic [31:0] din;
    logic [4:0]  wr_num;
    logic        rwe;
    logic        hlwe;
    logic [31:0] hi;
    logic [31:0] pc;
  } wb_bundle_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OpSb, OpSh, OpSw};
  endfunction

  function automatic logic is_half(input logic [5:0] op);
    return op inside {OpLh, OpLhu, OpSh};
  endfunction

  function automatic logic is_word(input logic [5:0] op);
    return op inside {OpLw, OpSw};
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    return (is_half(op) && a[0]) || (is_word(op) && (a != 2'b00));
  endfunction

  function automatic logic [31:0] align_addr(input logic [5:0] op, input logic [31:0] a);
    if (is_half(op)) return {a[31:1], 1'b0};
    if (is_word(op)) return {a[31:2], 2'b00};
    return a;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [5:0] op, input logic [1:0] a);
    if (is_half(op)) return BeHalf << {a[1], 1'b0};
    if (is_word(op)) return BeWord;
    return BeByte << a;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] d);
    if (is_half(op)) return {2{d[15:0]}};
    if (is_word(op)) return d;
    return {4{d[7:0]}};
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load-data lane select with sign/zero extension for LB/LH/LW/LBU/LHU.
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  a_i,
  input  logic [5:0]  opcode_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [15:0] half;

  assign shifted = rdata_i >> {a_i, 3'b000};
  assign half    = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    unique case (opcode_i)
      OpLb:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      OpLbu:   data_o = {24'd0, shifted[7:0]};
      OpLh:    data_o = {{16{half[15]}}, half};
      OpLhu:   data_o = {16'd0, half};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: request/ack data bus, load extension, registered WB bundle.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses instead of masking the address.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] Order_in,
  input  logic [31:0] Alu_in,
  input  logic [31:0] Store_Data,
  input  logic [4:0]  Write_Reg_num_in,
  input  logic        Reg_Write_enable_in,
  input  logic        HI_LO_Write_enable_in,
  input  logic [31:0] HI_in_in,
  input  logic [31:0] NextPC_in,
  input  logic        IntRequest,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] Order,
  output logic [31:0] RegFile_Din,
  output logic [4:0]  Write_Reg_num,
  output logic        Reg_Write_enable,
  output logic        HI_LO_Write_enable,
  output logic [31:0] HI_in,
  output logic [31:0] WB_NOINT_NextPC,
  output logic        bus_err,
  output logic        align_err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  wb_bundle_t      hold_q, hold_d, out_q, out_d, in_bundle;
  bus_req_t        req_q, req_d;
  logic            valid_q, valid_d, bus_err_q, bus_err_d, align_err_q, align_err_d;
  logic [5:0]      op_in;
  logic            in_mem, in_mis, timeout;
  logic [31:0]     load_data;

  assign op_in  = Order_in[31:26];
  assign in_mem = is_load(op_in) || is_store(op_in);
`ifdef MEM_ALIGN_CHECK_EN
  assign in_mis = in_mem && misaligned(op_in, Alu_in[1:0]);
`else
  assign in_mis = 1'b0;
`endif
  // cnt_q holds the number of ACCESS cycles already spent; fire in the TIMEOUT_CYCLES-th one.
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  assign in_bundle = '{order: Order_in, din: Alu_in, wr_num: Write_Reg_num_in,
                       rwe: Reg_Write_enable_in, hlwe: HI_LO_Write_enable_in,
                       hi: HI_in_in, pc: NextPC_in};

  mem_load_extend u_load_extend (
    .rdata_i  (mem_rdata),
    .a_i      (req_q.addr[1:0]),
    .opcode_i (hold_q.order[31:26]),
    .data_o   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    req_d       = req_q;
    out_d       = '0;
    valid_d     = 1'b0;
    bus_err_d   = 1'b0;
    align_err_d = 1'b0;
    stall       = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = valid_in && in_mem && !in_mis;
        if (valid_in && !IntRequest) begin
          if (!in_mem) begin
            out_d   = in_bundle;
            valid_d = 1'b1;
          end else if (in_mis) begin
            align_err_d = 1'b1;
          end else begin
            state_d = StAccess;
            cnt_d   = '0;
            hold_d  = in_bundle;
            req_d   = '{addr: align_addr(op_in, Alu_in), we: is_store(op_in),
                        be: byte_enable(op_in, Alu_in[1:0]),
                        wdata: store_lanes(op_in, Store_Data)};
          end
        end
      end
      StAccess: begin
        if (mem_ack) begin
          state_d = StIdle;
          if (!IntRequest) begin
            out_d   = hold_q;
            valid_d = 1'b1;
            if (is_load(hold_q.order[31:26])) out_d.din = load_data;
          end
        end else begin
          stall = 1'b1;
          if (IntRequest) begin
            state_d = StAbort;
          end else if (timeout) begin
            state_d   = StIdle;
            bus_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StAbort: begin
        // The bus cycle cannot be cancelled; wait for the ack and drop the result.
        stall = 1'b1;
        if (mem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hold_q      <= '0;
      req_q       <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      req_q       <= req_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
    end
  end

  assign mem_req            = (state_q != StIdle);
  assign mem_we             = req_q.we;
  assign mem_be             = req_q.be;
  assign mem_addr           = req_q.addr;
  assign mem_wdata          = req_q.wdata;
  assign wb_valid           = valid_q;
  assign Order              = out_q.order;
  assign RegFile_Din        = out_q.din;
  assign Write_Reg_num      = out_q.wr_num;
  assign Reg_Write_enable   = out_q.rwe;
  assign HI_LO_Write_enable = out_q.hlwe;
  assign HI_in              = out_q.hi;
  assign WB_NOINT_NextPC    = out_q.pc;
  assign bus_err            = bus_err_q;
  assign align_err          = align_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage against a size/offset arithmetic model.
module tb_mem_access_stage;

  localparam int unsigned Timeout = 4;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] ADD = 6'b000000;

  logic        clk = 1'b0, rst = 1'b0, valid_in = 1'b0, IntRequest = 1'b0, mem_ack = 1'b0;
  logic [31:0] Order_in = '0, Alu_in = '0, Store_Data = '0, HI_in_in = '0, NextPC_in = '0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  Write_Reg_num_in = '0;
  logic        Reg_Write_enable_in = 1'b0, HI_LO_Write_enable_in = 1'b0;
  logic        mem_req, mem_we, stall, wb_valid, Reg_Write_enable, HI_LO_Write_enable;
  logic        bus_err, align_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, Order, RegFile_Din, HI_in, WB_NOINT_NextPC;
  logic [4:0]  Write_Reg_num;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .Order_in(Order_in), .Alu_in(Alu_in),
    .Store_Data(Store_Data), .Write_Reg_num_in(Write_Reg_num_in),
    .Reg_Write_enable_in(Reg_Write_enable_in), .HI_LO_Write_enable_in(HI_LO_Write_enable_in),
    .HI_in_in(HI_in_in), .NextPC_in(NextPC_in), .IntRequest(IntRequest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .wb_valid(wb_valid), .Order(Order), .RegFile_Din(RegFile_Din),
    .Write_Reg_num(Write_Reg_num), .Reg_Write_enable(Reg_Write_enable),
    .HI_LO_Write_enable(HI_LO_Write_enable), .HI_in(HI_in), .WB_NOINT_NextPC(WB_NOINT_NextPC),
    .bus_err(bus_err), .align_err(align_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size, offset, lane arithmetic ----
  function automatic int size_of(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic logic is_ld(input logic [5:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU;
  endfunction

  function automatic logic [31:0] ref_addr(input logic [5:0] op, input logic [31:0] a);
    return a - (a % size_of(op));
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint full, md, v;
    int off, sz;
    sz   = size_of(op);
    off  = int'(ref_addr(op, a) % 4);
    full = {32'd0, rd};
    md   = longint'(1) << (8 * sz);
    v    = (full >> (8 * off)) % md;
    if ((op == LB || op == LH) && v >= md / 2) v = v - md;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_be(input logic [5:0] op, input logic [31:0] a);
    int be;
    be = ((1 << size_of(op)) - 1) << (ref_addr(op, a) % 4);
    return 32'(be);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] d);
    if (size_of(op) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (size_of(op) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    valid_in   = 1'b0;
    IntRequest = 1'b0;
    mem_ack    = 1'b0;
  endtask

  task automatic present(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd);
    Order_in              = {op, 26'($urandom)};
    Alu_in                = addr;
    Store_Data            = sd;
    Write_Reg_num_in      = 5'($urandom);
    Reg_Write_enable_in   = is_ld(op) ? 1'b1 : 1'($urandom);
    HI_LO_Write_enable_in = 1'($urandom);
    HI_in_in              = $urandom;
    NextPC_in             = $urandom;
    valid_in              = 1'b1;
  endtask

  task automatic check_retire(input string tag, input logic [31:0] exp_din);
    check({tag, "_wb_valid"}, wb_valid, 1);
    check({tag, "_order"}, Order, Order_in);
    check({tag, "_din"}, RegFile_Din, exp_din);
    check({tag, "_wrnum"}, Write_Reg_num, Write_Reg_num_in);
    check({tag, "_rwe"}, Reg_Write_enable, Reg_Write_enable_in);
    check({tag, "_hlwe"}, HI_LO_Write_enable, HI_LO_Write_enable_in);
    check({tag, "_hi"}, HI_in, HI_in_in);
    check({tag, "_pc"}, WB_NOINT_NextPC, NextPC_in);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_bub_valid"}, wb_valid, 0);
    check({tag, "_bub_order"}, Order, 0);
    check({tag, "_bub_rwe"}, Reg_Write_enable, 0);
    check({tag, "_bub_hlwe"}, HI_LO_Write_enable, 0);
  endtask

  // Memory op with ack in the k-th ACCESS cycle; bundle expected k+1 edges after arrival.
  task automatic mem_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rd, input int k, input string tag);
    logic [31:0] exp_din;
    exp_din = is_ld(op) ? ref_load(op, addr, rd) : addr;
    present(op, addr, sd);
    #1;
    check({tag, "_stall_arrive"}, stall, 1);
    tick();
    for (int c = 1; c <= k; c++) begin
      mem_ack   = (c == k);
      mem_rdata = (c == k) ? rd : $urandom;
      #1;
      check({tag, "_req"}, mem_req, 1);
      check({tag, "_we"}, mem_we, !is_ld(op));
      check({tag, "_be"}, mem_be, ref_be(op, addr));
      check({tag, "_addr"}, mem_addr, ref_addr(op, addr));
      check({tag, "_wdata"}, mem_wdata, is_ld(op) ? mem_wdata : ref_wdata(op, sd));
      check({tag, "_stall"}, stall, (c != k));
      tick();
    end
    check_retire(tag, exp_din);
    check({tag, "_req_done"}, mem_req, 0);
    set_idle();
    #1;
    check({tag, "_stall_done"}, stall, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [5:0] ops [9];
    logic [5:0] op;
    logic [31:0] addr;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADD};

    // Reset
    rst = 1'b0;
    tick();
    tick();
    check("rst_req", mem_req, 0);
    check("rst_valid", wb_valid, 0);
    check("rst_din", RegFile_Din, 0);
    check("rst_order", Order, 0);
    check("rst_be", mem_be, 0);
    check("rst_stall", stall, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_align_err", align_err, 0);
    rst = 1'b1;
    tick();

    // Non-memory op: one-edge latency, never stalls
    present(ADD, 32'h1234, 32'h0);
    #1;
    check("add_stall", stall, 0);
    tick();
    check_retire("add", 32'h1234);
    check("add_req", mem_req, 0);
    set_idle();
    tick();
    check_bubble("after_add");

    // Directed memory cases
    mem_txn(LB, 32'h103, 32'h0, 32'h80FF_0000, 1, "lb");
    mem_txn(SH, 32'h202, 32'hABCD, 32'h0, 3, "sh");
    mem_txn(LHU, 32'h102, 32'h0, 32'h8001_7F02, 2, "lhu");
    mem_txn(LH, 32'h100, 32'h0, 32'h1234_8765, 1, "lh");
    mem_txn(SB, 32'h301, 32'h5A, 32'h0, 1, "sb");

    // Timeout: no ack for Timeout ACCESS cycles
    present(LW, 32'h40, 32'h0);
    tick();
    for (int c = 1; c <= int'(Timeout); c++) begin
      check("to_req", mem_req, 1);
      check("to_stall", stall, 1);
      check("to_bus_err_early", bus_err, 0);
      tick();
    end
    check("to_req_drop", mem_req, 0);
    check("to_bus_err", bus_err, 1);
    check("to_rwe", Reg_Write_enable, 0);
    check("to_valid", wb_valid, 0);
    set_idle();
    tick();
    check("to_bus_err_pulse", bus_err, 0);

    // IntRequest in 2nd ACCESS cycle of SW: request held until ack, bubbles out
    present(SW, 32'h300, 32'hDEAD_BEEF);
    tick();
    check("abt_req1", mem_req, 1);
    tick();
    IntRequest = 1'b1;
    valid_in   = 1'b0;
    #1;
    check("abt_stall_int", stall, 1);
    tick();
    IntRequest = 1'b0;
    #1;
    check("abt_req_hold", mem_req, 1);
    check("abt_addr_hold", mem_addr, 32'h300);
    check("abt_stall", stall, 1);
    check_bubble("abt1");
    tick();
    mem_ack = 1'b1;
    #1;
    check("abt_req_ack", mem_req, 1);
    tick();
    mem_ack = 1'b0;
    #1;
    check("abt_req_idle", mem_req, 0);
    check("abt_stall_idle", stall, 0);
    check_bubble("abt_end");

    // IntRequest coinciding with ack: load discarded, straight back to idle
    present(LW, 32'h10, 32'h0);
    tick();
    mem_ack    = 1'b1;
    mem_rdata  = 32'h1111_2222;
    IntRequest = 1'b1;
    tick();
    check_bubble("int_ack");
    check("int_ack_req", mem_req, 0);
    set_idle();

    // IntRequest squashes a non-memory op
    present(ADD, 32'h55, 32'h0);
    IntRequest = 1'b1;
    tick();
    check_bubble("int_add");
    set_idle();

    // Reset mid-ACCESS drops mem_req on that edge
    present(LW, 32'h20, 32'h0);
    tick();
    check("rstm_req", mem_req, 1);
    rst = 1'b0;
    tick();
    check("rstm_req_drop", mem_req, 0);
    rst = 1'b1;
    set_idle();
    tick();

    // Misaligned word access
`ifdef MEM_ALIGN_CHECK_EN
    present(LW, 32'h2, 32'h0);
    #1;
    check("mis_req_arrive", mem_req, 0);
    tick();
    check("mis_align_err", align_err, 1);
    check("mis_req", mem_req, 0);
    check_bubble("mis");
    set_idle();
    tick();
    check("mis_align_err_pulse", align_err, 0);
`else
    mem_txn(LW, 32'h2, 32'h0, 32'hCAFE_F00D, 1, "mis");
    check("mis_align_err", align_err, 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      op   = ops[$urandom_range(8, 0)];
      addr = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      addr = ref_addr(op, addr);
`endif
      if (op == ADD) begin
        present(ADD, addr, 32'h0);
        #1;
        check("rnd_add_stall", stall, 0);
        tick();
        check_retire("rnd_add", addr);
        set_idle();
      end else begin
        mem_txn(op, addr, $urandom, $urandom, int'($urandom_range(3, 1)), "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
